// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the fetch PC through a combinational ROM and
// buffers {pc, word} pairs in a small prefetch FIFO for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_en,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc
);
    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [31:0] RESET_FPC  = {RESET_PC[31:2], 2'b00};

    logic [31:0]   r_fpc;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_word_mem [DEPTH];

    logic             w_pop;
    logic             w_push;
    logic [DEPTH-1:0] w_we;

    // A full FIFO can still accept a word in the same cycle its head leaves.
    assign w_pop  = o_instr_valid & i_instr_ready;
    assign w_push = i_fetch_en & ~i_redirect & ((r_count < FULL_COUNT) | w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_push & (r_wr_ptr == PW'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_word_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_pc_mem[i]   <= r_fpc;
                    r_word_mem[i] <= i_mem_data;
                end
            end
        end
    end

    // Redirect flushes everything; a pop in the same cycle is dropped, not consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fpc    <= RESET_FPC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect) begin
            r_fpc    <= {i_redirect_pc[31:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fpc    <= r_fpc + 32'd4;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_mem_addr    = r_fpc;
    assign o_instr_valid = (r_count != '0);
    assign o_instr       = r_word_mem[r_rd_ptr];
    assign o_instr_pc    = r_pc_mem[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a combinational ROM model feeds the DUT and each
// scenario task checks the decode-side outputs against hand-computed values.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [0:6] = '{32'h0000_0013, 32'h2000_00b7, 32'h0010_0113, 32'h0020_a023,
                               32'h0000_0113, 32'h0020_a023, 32'hfedf_f06f};

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[31:2] < 30'd7) return rom[a[4:2]];
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign mem_data = rom_word(mem_addr);

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fetch_en    (fetch_en),
        .o_mem_addr    (mem_addr),
        .i_mem_data    (mem_data),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rel_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        fetch_en = 1'b1;
        instr_ready = rdy;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
    endtask

    task automatic test_stream();
        rel_reset(1'b1);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_pre_valid got=%b want=0", instr_valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL stream_pre_addr got=%h want=0", mem_addr); end
        for (int i = 0; i < 7; i++) begin
            tick();
            $display("stream pop pc=%h instr=%h valid=%b", instr_pc, instr, instr_valid);
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, instr_valid); end
            total++; if (instr !== rom[i]) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, instr, rom[i]); end
            total++; if (instr_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, instr_pc, 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want_addr;
        rel_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            want_addr = (i == 0) ? 32'h4 : 32'h8;
            $display("hold cycle %0d addr=%h head pc=%h", i, mem_addr, instr_pc);
            total++; if (mem_addr !== want_addr) begin bad++; $display("FAIL bp_addr[%0d] got=%h want=%h", i, mem_addr, want_addr); end
            total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL bp_head_instr[%0d] got=%h want=00000013", i, instr); end
            total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc[%0d] got=%h want=0", i, instr_pc); end
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            $display("drain pop pc=%h instr=%h", instr_pc, instr);
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_pop_valid[%0d] got=%b want=1", k, instr_valid); end
            total++; if (instr_pc !== 32'(4 * k)) begin bad++; $display("FAIL bp_pop_pc[%0d] got=%h want=%h", k, instr_pc, 32'(4 * k)); end
            total++; if (instr !== rom[k]) begin bad++; $display("FAIL bp_pop_instr[%0d] got=%h want=%h", k, instr, rom[k]); end
            tick();
        end
    endtask

    // Continues from test_backpressure: FIFO holds pc 14 and 18, fetch PC at 1C.
    task automatic test_fetch_disable();
        fetch_en = 1'b0;
        total++; if (instr_pc !== 32'h14) begin bad++; $display("FAIL fd_head0 got=%h want=00000014", instr_pc); end
        tick();
        $display("fetch off pop, head pc=%h addr=%h", instr_pc, mem_addr);
        total++; if (instr_pc !== 32'h18) begin bad++; $display("FAIL fd_head1 got=%h want=00000018", instr_pc); end
        total++; if (mem_addr !== 32'h1C) begin bad++; $display("FAIL fd_addr1 got=%h want=0000001c", mem_addr); end
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fd_empty got=%b want=0", instr_valid); end
        total++; if (mem_addr !== 32'h1C) begin bad++; $display("FAIL fd_addr2 got=%h want=0000001c", mem_addr); end
    endtask

    task automatic test_full_push_pop();
        rel_reset(1'b0);
        tick(); tick(); tick();
        total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL fpp_full_addr got=%h want=00000008", mem_addr); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        $display("push+pop head pc=%h addr=%h", instr_pc, mem_addr);
        total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL fpp_pc got=%h want=00000004", instr_pc); end
        total++; if (instr !== 32'h2000_00b7) begin bad++; $display("FAIL fpp_instr got=%h want=200000b7", instr); end
        total++; if (mem_addr !== 32'hC) begin bad++; $display("FAIL fpp_addr got=%h want=0000000c", mem_addr); end
        tick();
        total++; if (mem_addr !== 32'hC) begin bad++; $display("FAIL fpp_still_full got=%h want=0000000c", mem_addr); end
        total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL fpp_head_hold got=%h want=00000004", instr_pc); end
    endtask

    task automatic test_redirect();
        rel_reset(1'b1);
        tick(); tick(); tick();
        total++; if (instr_pc !== 32'h8) begin bad++; $display("FAIL rd_pre_head got=%h want=00000008", instr_pc); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0007;
        tick();
        redirect = 1'b0;
        $display("redirect to %h: valid=%b addr=%h", redirect_pc, instr_valid, mem_addr);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b want=0", instr_valid); end
        total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL rd_addr got=%h want=00000004", mem_addr); end
        tick();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rd_new_valid got=%b want=1", instr_valid); end
        total++; if (instr !== 32'h2000_00b7) begin bad++; $display("FAIL rd_new_instr got=%h want=200000b7", instr); end
        total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL rd_new_pc got=%h want=00000004", instr_pc); end
        tick();
        total++; if (instr_pc !== 32'h8) begin bad++; $display("FAIL rd_next_pc got=%h want=00000008", instr_pc); end
        redirect = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_pc = 32'h1B;
        tick();
        redirect = 1'b0;
        $display("back-to-back redirect: valid=%b addr=%h", instr_valid, mem_addr);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b want=0", instr_valid); end
        total++; if (mem_addr !== 32'h18) begin bad++; $display("FAIL b2b_addr got=%h want=00000018", mem_addr); end
        tick();
        total++; if (instr_pc !== 32'h18) begin bad++; $display("FAIL b2b_pc got=%h want=00000018", instr_pc); end
        total++; if (instr !== 32'hfedf_f06f) begin bad++; $display("FAIL b2b_instr got=%h want=fedff06f", instr); end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b1;
        fetch_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        total++; if (mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h want=fffffffc", mem_addr); end
        tick();
        $display("wrap pop pc=%h instr=%h addr=%h", instr_pc, instr, mem_addr);
        total++; if (instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h want=fffffffc", instr_pc); end
        total++; if (instr !== 32'h3F21_FFFC) begin bad++; $display("FAIL wrap_instr got=%h want=3f21fffc", instr); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h want=0", mem_addr); end
        tick();
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL wrap_next_pc got=%h want=0", instr_pc); end
        total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL wrap_next_instr got=%h want=00000013", instr); end
    endtask

    task automatic test_async_reset();
        rel_reset(1'b0);
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        $display("async reset: valid=%b addr=%h instr=%h pc=%h", instr_valid, mem_addr, instr, instr_pc);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", instr_valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL ar_addr got=%h want=0", mem_addr); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL ar_instr got=%h want=0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL ar_pc got=%h want=0", instr_pc); end
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ar_held_valid got=%b want=0", instr_valid); end
        @(negedge clk);
        instr_ready = 1'b1;
        #2;
        rst = 1'b0;
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL ar_rel_addr got=%h want=0", mem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("post-reset pop pc=%h instr=%h", instr_pc, instr);
            total++; if (instr_pc !== 32'(4 * i)) begin bad++; $display("FAIL ar_stream_pc[%0d] got=%h want=%h", i, instr_pc, 32'(4 * i)); end
            total++; if (instr !== rom[i]) begin bad++; $display("FAIL ar_stream_instr[%0d] got=%h want=%h", i, instr, rom[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_fetch_disable();
        test_full_push_pop();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
